clz_seq_ctrl: RTL and testbench
===============================

# clz_seq_ctrl

Multi-cycle sequencer for the count-leading-zeros/ones operation of the CPU datapath. It replaces the 32-bit priority chain with one narrow chunk counter, which it steps from the MSB chunk downward, one chunk per cycle. The block accumulates the count and reports completion through a start/busy/done handshake to the instruction control unit. It serves both CLZ and CLO; CLO is formed by inverting the operand at capture.

## Interface
- CHUNK_W, default 8: chunk width scanned per cycle; legal values 4, 8, 16 (must divide 32).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_clo  in  1  0 = CLZ, 1 = CLO; sampled with start.
- operand  in  32  source value; sampled with start.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse, high in DONE.
- result  out  32  count 0..32, zero-extended; held until the next completion.

## Operation
- States:
  - IDLE: start=1 at edge E0 latches the word (operand, or ~operand when op_clo=1), clears the count, sets the chunk index to 0 (bits [31:32-CHUNK_W]) and moves to SCAN.
  - SCAN: each cycle examines chunk idx.
    - Chunk all-zero: count += CHUNK_W.
    - Otherwise: count += leading zeros of the chunk; mark found.
    - Move to DONE after the last chunk (idx = 32/CHUNK_W-1), or earlier as set under Configuration.
  - DONE: done=1; result is loaded from the count at the DONE entry edge; next state is IDLE unconditionally.
- start is ignored while busy=1 and is not queued. A start in the DONE cycle is dropped. start may be accepted in the first IDLE cycle after DONE.
- Once found is set, the count freezes; later chunks do not contribute.
- Width rules:
  - count register is 6 bits; its maximum is 32 (all-zero CLZ, all-ones CLO).
  - result = {26'b0, count}.
  - The chunk sub-count is $clog2(CHUNK_W)+1 bits.
- Reset values: state IDLE, busy 0, done 0, result 0, count 0, found 0.
- Asserting rst during SCAN or DONE aborts the operation: no done pulse and result is 0 after reset.

## Timing
- Scans occupy the cycles following E0..E(n-1). DONE is entered at En, so done is high between En and En+1. busy is high from E0 to En+1.
- Operand/op_clo are don't-care after E0.
- result changes only at a DONE entry edge or on reset.
- n depends on the macro (below). Back-to-back throughput is one operation per n+2 cycles.

## Configuration
- CLZ_SEQ_EARLY_EXIT_EN defined:
  - SCAN leaves at the first nonzero chunk.
  - n = (index of first nonzero chunk)+1; n = 32/CHUNK_W for an all-zero word.
- Undefined:
  - Fixed latency, n = 32/CHUNK_W always; the remaining chunks are scanned with the count frozen.
  - Results are identical in both modes; only latency differs.

## Structure
- Package clz_pkg holds:
  - state enum typedef (IDLE, SCAN, DONE);
  - localparam DATA_W = 32;
  - CNT_W = 6.
- Sub-module clz_chunk: combinational leading-zero count of a CHUNK_W-bit input, output 0..CHUNK_W. This is the only priority logic. The controller holds the FSM, index counter, accumulator and found flag.

## Test plan
- CLZ, operand 0x00F00000, CHUNK_W=8:
  - result 8 in both modes.
  - early-exit build: done high after E2.
  - fixed build: done high after E4.
- CLZ, operand 0x00000000 -> result 32, done after E4 in both modes. CLO, operand 0xFFFFFFFF -> result 32.
- CLO, operand 0xFFF0_1234 -> result 12. CLZ, operand 0x80000000 -> result 0, early-exit done after E1.
- start held high continuously with alternating operands:
  - one operation per n+2 cycles;
  - pulses during busy (including the DONE cycle) are dropped;
  - result is stable between done pulses.
- rst asserted mid-SCAN:
  - busy, done and result go to 0 immediately (asynchronously);
  - no done pulse;
  - a new start after deassertion completes correctly.
- Sweep CHUNK_W ∈ {4, 8, 16}:
  - random operands cover every leading-zero count 0..32;
  - each result matches the reference priority count;
  - early-exit n matches the first-nonzero-chunk index.

Source files
------------

// File: rtl/clz_pkg.sv
// Shared types and widths for the multi-cycle count-leading-zeros/ones sequencer.
package clz_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/clz_chunk.sv
// Combinational leading-zero count of one CHUNK_W-bit chunk; all-zero yields CHUNK_W.
module clz_chunk #(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0]         chunk,
    output logic [$clog2(CHUNK_W):0]   lz
);

    localparam int unsigned LZ_W = $clog2(CHUNK_W) + 1;

    // Scanning upward lets the highest set bit win.
    always_comb begin
        lz = LZ_W'(CHUNK_W);
        for (int unsigned i = 0; i < CHUNK_W; i++) begin
            if (chunk[i]) begin
                lz = LZ_W'(CHUNK_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/clz_seq_ctrl.sv
// Sequencer stepping a narrow leading-zero counter over a 32-bit word, MSB chunk first.
// Define CLZ_SEQ_EARLY_EXIT_EN to stop scanning at the first nonzero chunk.
module clz_seq_ctrl
    import clz_pkg::*;
#(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_clo,
    input  logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned N_CHUNK = DATA_W / CHUNK_W;
    localparam int unsigned IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam int unsigned LZ_W    = $clog2(CHUNK_W) + 1;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   word;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    count;
    logic                found;
    logic [LZ_W-1:0]     lz;
    logic                chunk_nz;
    logic                last_chunk;
    logic [CNT_W-1:0]    count_upd;
    logic                busy_nxt;
    logic                done_nxt;

    // The word shifts left each scan cycle, so the current chunk is always on top.
    clz_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .chunk (word[DATA_W-1 -: CHUNK_W]),
        .lz    (lz)
    );

    assign chunk_nz   = (lz != LZ_W'(CHUNK_W));
    assign last_chunk = (idx == IDX_W'(N_CHUNK - 1));
    assign count_upd  = found ? count : CNT_W'(count + CNT_W'(lz));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
`ifdef CLZ_SEQ_EARLY_EXIT_EN
                if (last_chunk || chunk_nz) begin
                    state_nxt = DONE;
                end
`else
                if (last_chunk) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, registered below so busy/done come straight from flops
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state_nxt != IDLE) begin
            busy_nxt = 1'b1;
        end
        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // Datapath: captured word, chunk index, frozen-after-found accumulator, result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word   <= '0;
            idx    <= '0;
            count  <= '0;
            found  <= 1'b0;
            result <= '0;
        end else begin
            if (state == IDLE && start) begin
                word  <= op_clo ? ~operand : operand;
                idx   <= '0;
                count <= '0;
                found <= 1'b0;
            end else if (state == SCAN) begin
                word  <= word << CHUNK_W;
                idx   <= IDX_W'(idx + 1'b1);
                count <= count_upd;
                found <= found | chunk_nz;
                if (state_nxt == DONE) begin
                    result <= DATA_W'(count_upd);
                end
            end
        end
    end

endmodule

// File: tb/tb_clz_seq_ctrl.sv
// Scoreboard bench running CHUNK_W = 4, 8 and 16 instances side by side on shared stimulus.
module tb_clz_seq_ctrl;

    typedef struct {
        int exp_res;
        int exp_n;
        int start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_clo = 1'b0;
    logic [31:0] operand = '0;
    logic        busy_v [3];
    logic        done_v [3];
    logic [31:0] result_v [3];

    exp_t sb [3][$];
    int   last_res [3];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        clz_seq_ctrl #(.CHUNK_W(4 << g)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .op_clo  (op_clo),
            .operand (operand),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .result  (result_v[g])
        );
    end

    function automatic int chunk_w(input int g);
        return 4 << g;
    endfunction

    function automatic int exp_n(input int w, input int lz);
`ifdef CLZ_SEQ_EARLY_EXIT_EN
        return (lz >= 32) ? 32 / w : lz / w + 1;
`else
        return 32 / w + 0 * lz;
`endif
    endfunction

    function automatic int ref_cnt(input logic [31:0] v, input logic clo);
        logic [31:0] x;
        x = clo ? ~v : v;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return 31 - i;
        end
        return 32;
    endfunction

    // Monitor: pops an expectation on each done pulse; otherwise result must hold.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                last_res[g] = 0;
            end else if (done_v[g]) begin
                checks = checks + 1;
                if (sb[g].size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_done w=%0d cyc=%0d result=%0d", chunk_w(g), cyc, result_v[g]);
                end else begin
                    exp_t e;
                    e = sb[g].pop_front();
                    if (result_v[g] != 32'(e.exp_res)) begin
                        failures = failures + 1;
                        $display("FAIL result w=%0d got=%0d exp=%0d", chunk_w(g), result_v[g], e.exp_res);
                    end
                    checks = checks + 1;
                    if (cyc - e.start_cyc != e.exp_n) begin
                        failures = failures + 1;
                        $display("FAIL latency w=%0d got=%0d exp=%0d", chunk_w(g), cyc - e.start_cyc, e.exp_n);
                    end
                    last_res[g] = e.exp_res;
                end
            end else begin
                checks = checks + 1;
                if (result_v[g] != 32'(last_res[g])) begin
                    failures = failures + 1;
                    $display("FAIL result_hold w=%0d got=%0d exp=%0d", chunk_w(g), result_v[g], last_res[g]);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy_v[0] && !busy_v[1] && !busy_v[2] &&
                sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) return;
        end
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL idle_timeout got=busy exp=idle cyc=%0d", cyc);
    endtask

    // Called at a negedge; the next posedge is the capture edge E0.
    task automatic issue(input logic clo, input logic [31:0] opnd, input int exp_res);
        exp_t e;
        start   = 1'b1;
        op_clo  = clo;
        operand = opnd;
        for (int g = 0; g < 3; g++) begin
            e.exp_res   = exp_res;
            e.exp_n     = exp_n(chunk_w(g), exp_res);
            e.start_cyc = cyc + 1;
            sb[g].push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        operand = $urandom;
        op_clo  = 1'($urandom);
        wait_idle();
    endtask

    task automatic check_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            checks = checks + 1;
            if (busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 || result_v[g] !== 32'd0) begin
                failures = failures + 1;
                $display("FAIL %s w=%0d busy=%b done=%b result=%0d exp=0/0/0",
                         tag, chunk_w(g), busy_v[g], done_v[g], result_v[g]);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          base;
        int          n_edges;
        exp_t        e;

        #1 check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed counts
        issue(1'b0, 32'h00F0_0000, 8);
        issue(1'b0, 32'h0000_0000, 32);
        issue(1'b1, 32'hFFFF_FFFF, 32);
        issue(1'b1, 32'hFFF0_1234, 12);
        issue(1'b0, 32'h8000_0000, 0);
        issue(1'b0, 32'h0000_0001, 31);
        issue(1'b1, 32'h7FFF_FFFF, 0);

        // start held high, operand alternating every cycle; predict each instance's accepts
        a = 32'h00F0_0000;
        b = 32'h0000_0F00;
        n_edges = 40;
        base = cyc;
        for (int g = 0; g < 3; g++) begin
            int t;
            t = 0;
            while (t < n_edges) begin
                int lz;
                lz = ref_cnt((t % 2 == 0) ? a : b, 1'b0);
                e.exp_res   = lz;
                e.exp_n     = exp_n(chunk_w(g), lz);
                e.start_cyc = base + t + 1;
                sb[g].push_back(e);
                t = t + e.exp_n + 2;
            end
        end
        op_clo = 1'b0;
        for (int j = 0; j < n_edges; j++) begin
            start   = 1'b1;
            operand = (j % 2 == 0) ? a : b;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Abort mid-scan: everything clears asynchronously, no done pulse follows
        issue(1'b0, 32'h0001_0000, 15);
        start   = 1'b1;
        op_clo  = 1'b0;
        operand = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_zero("no_done_after_abort");
        issue(1'b1, 32'hFF00_0000, 8);

        // Sweep every leading-zero/one count 0..32 for both operations
        for (int k = 0; k <= 32; k++) begin
            for (int c = 0; c < 2; c++) begin
                logic [31:0] v;
                logic [31:0] rnd;
                rnd = $urandom;
                if (k == 32) v = 32'h0;
                else         v = (32'h8000_0000 >> k) | (rnd & ((32'h8000_0000 >> k) - 32'h1));
                if (c == 1) v = ~v;
                issue(1'(c), v, ref_cnt(v, 1'(c)));
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
